// File: rtl/memory_responder.sv
// Memory-mapped bus responder: RAM, a down-counting timer with interrupt,
// a general-purpose output port and a fixed reset vector, all with one-cycle registered reads.
module memory_responder #(
    parameter int unsigned RAM_AW       = 10,
    parameter logic [15:0] IO_BASE      = 16'hD000,
    parameter logic [15:0] RESET_VECTOR = 16'h8000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    output logic [7:0]  port_out,
    output logic        irq_n
);
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    logic [7:0] ram_mem [RAM_DEPTH];
    logic [7:0] ram_rd_q;
    logic       sel_ram_q;
    logic [7:0] reg_rd_q, reg_rd_d;

    logic [7:0] count_q, count_d;
    logic [7:0] reload_q, reload_d;
    logic [7:0] port_q, port_d;
    logic       en_q, en_d;
    logic       ie_q, ie_d;
    logic       auto_q, auto_d;
    logic       uf_q, uf_d;

    logic              hit_ram, hit_io, underflow, status_rd;
    logic [15:0]       io_delta;
    logic [1:0]        io_off;
    logic [RAM_AW-1:0] ram_addr;

    assign hit_ram   = (address >> RAM_AW) == 16'd0;
    assign io_delta  = address - IO_BASE;
    assign hit_io    = !hit_ram && (io_delta < 16'd4);
    assign io_off    = io_delta[1:0];
    assign ram_addr  = address[RAM_AW-1:0];
    assign underflow = en_q && (count_q == 8'd0);
    assign status_rd = read_write && hit_io && (io_off == 2'd2);

    // Read data for everything except RAM; RAM has its own registered port.
    always_comb begin
        reg_rd_d = 8'hFF;
        if (hit_io) begin
            case (io_off)
                2'd0:    reg_rd_d = count_q;
                2'd1:    reg_rd_d = {5'b0, auto_q, ie_q, en_q};
                2'd2:    reg_rd_d = {7'b0, uf_q};
                default: reg_rd_d = port_q;
            endcase
        end else if (address == 16'hFFFC) begin
            reg_rd_d = RESET_VECTOR[7:0];
        end else if (address == 16'hFFFD) begin
            reg_rd_d = RESET_VECTOR[15:8];
        end
    end

    // Timer first, then register writes so a same-cycle write overrides the timer.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        port_d   = port_q;
        en_d     = en_q;
        ie_d     = ie_q;
        auto_d   = auto_q;
        uf_d     = underflow || (uf_q && !status_rd);
        if (en_q) begin
            if (count_q != 8'd0) begin
                count_d = count_q - 8'd1;
            end else if (auto_q) begin
                count_d = reload_q;
            end else begin
                en_d = 1'b0;
            end
        end
        if (!read_write && hit_io) begin
            case (io_off)
                2'd0: begin
                    count_d  = data_write;
                    reload_d = data_write;
                end
                2'd1: begin
                    en_d   = data_write[0];
                    ie_d   = data_write[1];
                    auto_d = data_write[2];
                end
                2'd3:    port_d = data_write;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= 8'd0;
            reload_q  <= 8'd0;
            port_q    <= 8'd0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            auto_q    <= 1'b0;
            uf_q      <= 1'b0;
            sel_ram_q <= 1'b0;
            reg_rd_q  <= 8'd0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            port_q   <= port_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            auto_q   <= auto_d;
            uf_q     <= uf_d;
            if (read_write) begin
                sel_ram_q <= hit_ram;
                reg_rd_q  <= reg_rd_d;
            end
        end
    end

    // RAM contents survive reset; only the write is blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (read_write) begin
            ram_rd_q <= ram_mem[ram_addr];
        end else if (reset_n && hit_ram) begin
            ram_mem[ram_addr] <= data_write;
        end
    end

    assign data_read = sel_ram_q ? ram_rd_q : reg_rd_q;
    assign port_out  = port_q;
    assign irq_n     = !(uf_q && ie_q);
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter RAM_AW, default 10, is the RAM address width; RAM spans $0000..(2^RAM_AW)-1.
REQ-002 Parameter IO_BASE, default 16'hD000, is the base of four I/O registers at IO_BASE+0..+3.
REQ-003 Parameter RESET_VECTOR, default 16'h8000, is the value returned at $FFFC (low byte) and $FFFD (high byte).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 address  input  16  CPU bus address.
REQ-007 read_write  input  1  1 = read cycle, 0 = write cycle.
REQ-008 data_write  input  8  CPU write data.
REQ-009 data_read  output  8  registered read data to CPU.
REQ-010 port_out  output  8  general-purpose output port (PORT register).
REQ-011 irq_n  output  1  active-low timer interrupt request.

Function
REQ-012 Decode SHALL be: RAM range; I/O range; $FFFC/$FFFD vector; everything else unmapped.
REQ-013 Unmapped reads SHALL return 8'hFF; unmapped and vector writes SHALL be ignored.
REQ-014 Read latency SHALL be one cycle: address sampled at edge N, data_read valid after edge N, held until the next read edge.
REQ-015 During write cycles data_read SHALL hold its previous value.
REQ-016 Writes SHALL commit at the sampling edge; a read of the same address on the following cycle SHALL return the new value.
REQ-017 I/O map: +0 CNT (R current count; W loads count and reload value), +1 CTRL (bit0 EN, bit1 IE, bit2 AUTO; bits 7:3 read 0), +2 STATUS (bit0 UF; read clears; writes ignored), +3 PORT (R/W, drives port_out).
REQ-018 With EN=1 and count>0, count SHALL decrement by 1 each cycle.
REQ-019 With EN=1 and count=0: UF set; if AUTO=1 count reloads from reload value; if AUTO=0 count stays 0 and EN clears.
REQ-020 A CNT write in the same cycle as a decrement or reload SHALL win; UF is not set that cycle by that write.
REQ-021 A STATUS read coinciding with an underflow SHALL return the pre-update UF and leave UF=1 (set wins over clear).
REQ-022 irq_n SHALL equal NOT(UF AND IE), derived from registered state only.
REQ-023 A CTRL write with EN=1 while count=0 and AUTO=0 SHALL underflow on the next cycle.
REQ-024 Count SHALL never wrap below 0 to 8'hFF except via reload.

Reset
REQ-025 While reset_n=0 at an edge: data_read=8'h00, port_out=8'h00, irq_n=1, count=0, reload=0, CTRL=0, UF=0.
REQ-026 Reset SHALL override any coincident write or timer event; RAM writes are suppressed that edge; RAM contents are not cleared.
REQ-027 Reset asserted mid-countdown SHALL stop the timer with no UF or irq on release.

Verification
REQ-028 RAM: write $5A to $0123, read $0123 next cycle -> data_read=$5A one cycle after the read address; read $0400 -> $FF.
REQ-029 Vectors: read $FFFC then $FFFD -> $00 then $80; write $12 to $FFFC, reread -> still $00.
REQ-030 One-shot: CNT<=3, CTRL<=$03 -> UF set and irq_n=0 four cycles after CTRL write; EN reads 0; count 0; STATUS read returns $01, then irq_n=1 and next STATUS read $00.
REQ-031 Auto-reload: CNT<=2, CTRL<=$05 -> UF every 3 cycles, count sequence 2,1,0,2,1,0; irq_n stays 1 (IE=0).
REQ-032 Collision: STATUS read on the underflow cycle -> returns $00, UF=1 afterwards; CNT write on a reload cycle -> count equals written value.
REQ-033 Reset: assert reset_n=0 mid-countdown with PORT=$A5 -> port_out=$00, irq_n=1, CTRL=$00; previously written RAM byte still readable.
